// File: rtl/serial_pkg.sv
// Shared serial definitions for the "Hello" detector.
//   byte_t      : 8-bit byte as moved between receiver and matcher
//   rx_state_e  : UART receiver FSM states
//   MESSAGE     : the constant sequence "Hello" (MSG_LEN characters, 'H' in the top byte)
//   msg_char()  : character of MESSAGE at a given index (0 = 'H')
package serial_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam int MSG_LEN = 5;
  localparam logic [8*MSG_LEN-1:0] MESSAGE = "Hello";
  localparam byte_t CHAR_H = MESSAGE[8*MSG_LEN-1 -: 8];

  // Index 0 is the first character sent; out-of-range indices return 0.
  function automatic byte_t msg_char(input logic [2:0] idx);
    byte_t c;
    c = 8'h00;
    for (int k = 0; k < MSG_LEN; k++) begin
      if (idx == 3'(k)) c = MESSAGE[8*(MSG_LEN-1-k) +: 8];
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with a two-flop input synchronizer.
//   clk         : sole clock, rising edge
//   rst         : synchronous active-high reset
//   rx          : asynchronous serial line, idle high
//   data        : last correctly framed byte
//   valid       : one-cycle pulse when data is updated
//   frame_error : one-cycle pulse when the stop bit is sampled low
module uart_rx
  import serial_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 5
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rx,
  output byte_t data,
  output logic  valid,
  output logic  frame_error
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);

  logic rx_meta_q, rx_sync_q, rx_prev_q;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  byte_t            shift_q, shift_d;
  byte_t            data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // rx_prev_q is the synchronized line one cycle earlier: this is a falling edge.
        if (rx_prev_q && !rx_sync_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          // Line back high at mid start bit means it was a glitch: drop it silently.
          state_d = rx_sync_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_IDLE: begin
        // A held-low break must not re-trigger: wait for the line to return high.
        if (rx_sync_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every flop samples pre-edge values
    // regardless of statement order.
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_error = ferr_q;

endmodule

// File: rtl/hello_detect.sv
// Detects the byte sequence "Hello" on a UART line and counts detections.
//   clk         : sole clock, rising edge
//   rst         : synchronous active-high reset
//   rx          : asynchronous serial line, idle high, 8N1, LSB first
//   rx_data     : last correctly framed byte
//   rx_valid    : one-cycle pulse when rx_data is updated
//   frame_error : one-cycle pulse when a stop bit is sampled low
//   detected    : one-cycle pulse the cycle after the final 'o' is received
//   match_count : number of detections, saturating at 255
//   receiving   : high while the matcher is partway through the sequence
module hello_detect
  import serial_pkg::*;
#(
  parameter int CLOCK_RATE     = 5,
  parameter int BAUD_RATE      = 1,
  parameter int CLOCKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       detected,
  output logic [7:0] match_count,
  output logic       receiving
);

  localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

  byte_t      byte_w;
  logic       valid_w, ferr_w;

  logic [2:0] idx_q, idx_d;
  logic       det_q, det_d;
  logic [7:0] count_q, count_d;

  uart_rx #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (byte_w),
    .valid      (valid_w),
    .frame_error(ferr_w)
  );

  always_comb begin
    idx_d   = idx_q;
    det_d   = 1'b0;
    count_d = count_q;

    if (ferr_w) begin
      idx_d = '0;
    end else if (valid_w) begin
      if (byte_w == msg_char(idx_q)) begin
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          det_d = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        // "Hello" has no internal repeats, so the only useful fallback is a fresh 'H'.
        idx_d = (byte_w == CHAR_H) ? 3'd1 : 3'd0;
      end
    end

    if (det_d && count_q != 8'hFF) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      det_q   <= 1'b0;
      count_q <= '0;
    end else begin
      idx_q   <= idx_d;
      det_q   <= det_d;
      count_q <= count_d;
    end
  end

  assign rx_data     = byte_w;
  assign rx_valid    = valid_w;
  assign frame_error = ferr_w;
  assign detected    = det_q;
  assign match_count = count_q;
  assign receiving   = (idx_q != 3'd0);

endmodule

// File: tb/tb_hello_detect.sv
// Self-checking bench for hello_detect with CLOCKS_PER_BIT = 5.
// A negedge monitor compares every rx_valid / frame_error / detected pulse
// against an expected-event scoreboard filled by a string-level model.
module tb_hello_detect;

  localparam int CPB       = 5;
  localparam int VALID_LAT = 2 + CPB / 2 + 9 * CPB;

  typedef logic [7:0] b8_t;
  typedef struct {
    int  cyc;
    b8_t data;
    b8_t cnt;
  } ev_t;
  typedef struct {
    string s;
    int    det;
    bit    recv;
    int    cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst, rx;
  logic [7:0] rx_data, match_count;
  logic rx_valid, frame_error, detected, receiving;

  int checks = 0, failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int valid_seen = 0, ferr_seen = 0, det_seen = 0;

  ev_t exp_v[$], exp_f[$], exp_d[$];
  b8_t hist[$];
  int  total_det = 0;
  string msg = "Hello";

  hello_detect #(.CLOCK_RATE(5), .BAUD_RATE(1)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_error(frame_error), .detected(detected), .match_count(match_count),
    .receiving(receiving)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic b8_t model_count();
    return (total_det > 255) ? 8'd255 : 8'(total_det);
  endfunction

  // Matcher is partway iff some suffix of the history is a proper prefix of "Hello".
  function automatic bit model_recv();
    for (int len = 1; len < 5; len++) begin
      if (hist.size() >= len) begin
        bit ok = 1'b1;
        for (int j = 0; j < len; j++)
          if (hist[hist.size() - len + j] != msg[j]) ok = 1'b0;
        if (ok) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_good(input b8_t b, input int t0);
    bit hit;
    hist.push_back(b);
    if (hist.size() > 5) void'(hist.pop_front());
    hit = (hist.size() == 5);
    for (int j = 0; j < 5 && hit; j++) if (hist[j] != msg[j]) hit = 1'b0;
    exp_v.push_back('{t0 + VALID_LAT, b, 8'h00});
    if (hit) begin
      total_det++;
      exp_d.push_back('{t0 + VALID_LAT + 1, 8'h00, model_count()});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_v.delete(); exp_f.delete(); exp_d.delete();
    hist.delete();
    total_det = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one frame starting at the current negedge. abort_bit >= 0 pulses
  // reset partway through that data bit and releases the line.
  task automatic send_frame(input b8_t b, input bit stop_ok, input int abort_bit);
    int t0;
    t0 = cyc + 1;
    if (abort_bit < 0) begin
      if (stop_ok) model_good(b, t0);
      else begin
        exp_f.push_back('{t0 + VALID_LAT, 8'h00, 8'h00});
        hist.delete();
      end
    end
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (abort_bit == i) begin
        repeat (2) @(negedge clk);
        rx = 1'b1;
        do_reset();
        return;
      end
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1, -1);
  endtask

  always @(negedge clk) begin
    ev_t ev;
    if (mon_en) begin
      if (exp_v.size() != 0 && exp_v[0].cyc == cyc) begin
        ev = exp_v.pop_front();
        check("rx_valid_at_cycle", rx_valid, 1);
        check("rx_data", rx_data, ev.data);
      end else if (rx_valid) check("rx_valid_unexpected", rx_valid, 0);

      if (exp_f.size() != 0 && exp_f[0].cyc == cyc) begin
        void'(exp_f.pop_front());
        check("frame_error_at_cycle", frame_error, 1);
      end else if (frame_error) check("frame_error_unexpected", frame_error, 0);

      if (exp_d.size() != 0 && exp_d[0].cyc == cyc) begin
        ev = exp_d.pop_front();
        check("detected_at_cycle", detected, 1);
        check("match_count_at_detect", match_count, ev.cnt);
      end else if (detected) check("detected_unexpected", detected, 0);

      if (rx_valid)    valid_seen++;
      if (frame_error) ferr_seen++;
      if (detected)    det_seen++;
    end
  end

  initial begin
    vec_t vecs[10];
    b8_t  alpha[5];
    int   d0, v0, f0;

    vecs[0] = '{"Hello",      1, 1'b0, 1};
    vecs[1] = '{"HHello",     1, 1'b0, 2};
    vecs[2] = '{"HelHello",   1, 1'b0, 3};
    vecs[3] = '{"Helo",       0, 1'b0, 3};
    vecs[4] = '{"HelHel",     0, 1'b1, 3};
    vecs[5] = '{"lo",         1, 1'b0, 4};
    vecs[6] = '{"Hell",       0, 1'b1, 4};
    vecs[7] = '{"xHello",     1, 1'b0, 5};
    vecs[8] = '{"HelloHello", 2, 1'b0, 7};
    vecs[9] = '{"hello",      0, 1'b0, 7};
    alpha[0] = 8'h48; alpha[1] = 8'h65; alpha[2] = 8'h6C; alpha[3] = 8'h6F; alpha[4] = 8'h78;

    // Reset state
    rst = 1'b1; rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_frame_error", frame_error, 0);
    check("reset_detected", detected, 0);
    check("reset_match_count", match_count, 0);
    check("reset_receiving", receiving, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    // One-cycle glitch, then a clean 'H'
    v0 = valid_seen;
    rx = 1'b0; @(negedge clk); rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_valid", valid_seen - v0, 0);
    send_frame(8'h48, 1'b1, -1);
    repeat (10) @(negedge clk);
    check("h_single_valid", valid_seen - v0, 1);
    check("h_rx_data", rx_data, 8'h48);
    check("h_receiving", receiving, 1);

    // Table-driven sequences, each sent back-to-back
    for (int i = 0; i < 10; i++) begin
      d0 = det_seen;
      send_str(vecs[i].s);
      repeat (10) @(negedge clk);
      check({"vec_det_", vecs[i].s}, det_seen - d0, vecs[i].det);
      check({"vec_recv_", vecs[i].s}, receiving, vecs[i].recv);
      check({"vec_count_", vecs[i].s}, match_count, vecs[i].cnt);
    end

    // Bad stop bit followed by a 30-cycle break
    send_str("He");
    repeat (5) @(negedge clk);
    check("pre_break_receiving", receiving, 1);
    f0 = ferr_seen;
    send_frame(8'h6C, 1'b0, -1);
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("break_one_frame_error", ferr_seen - f0, 1);
    check("break_rx_data_kept", rx_data, 8'h65);
    check("break_receiving", receiving, 0);
    d0 = det_seen;
    send_str("Hello");
    repeat (10) @(negedge clk);
    check("after_break_detect", det_seen - d0, 1);

    // Reset during data bit 4 of the 'l' in "Hello"
    do_reset();
    repeat (5) @(negedge clk);
    v0 = valid_seen;
    send_str("Hel");
    send_frame(8'h6C, 1'b1, 4);
    v0 = valid_seen;
    repeat (100) @(negedge clk);
    check("abort_no_valid", valid_seen - v0, 0);
    check("abort_match_count", match_count, 0);
    check("abort_receiving", receiving, 0);
    check("abort_rx_data", rx_data, 0);
    d0 = det_seen;
    send_str("Hello");
    repeat (10) @(negedge clk);
    check("post_abort_detect", det_seen - d0, 1);
    check("post_abort_count", match_count, 1);

    // Randomized traffic against the string-level model
    for (int n = 0; n < 100; n++) begin
      int  r;
      b8_t b;
      bit  ok;
      r  = $urandom_range(0, 9);
      b  = (r < 5) ? alpha[r] : 8'($urandom);
      ok = ($urandom_range(0, 19) != 0);
      send_frame(b, ok, -1);
      if (!ok) begin
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
      end else if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 7)) @(negedge clk);
      end
    end
    repeat (80) @(negedge clk);
    check("random_receiving", receiving, model_recv());
    check("random_match_count", match_count, model_count());

    // Saturation
    do_reset();
    repeat (5) @(negedge clk);
    d0 = det_seen;
    for (int k = 0; k < 260; k++) send_str("Hello");
    repeat (20) @(negedge clk);
    check("sat_detect_pulses", det_seen - d0, 260);
    check("sat_match_count", match_count, 255);

    check("events_pending_valid", exp_v.size(), 0);
    check("events_pending_ferr", exp_f.size(), 0);
    check("events_pending_det", exp_d.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hello_detect.md
HELLO_DETECT -- requirements
Module: hello_detect

Interface
REQ-001 Parameter CLOCK_RATE, default 5, system clock frequency in Hz (100_000_000 on hardware).
REQ-002 Parameter BAUD_RATE, default 1, serial bit rate (115_200 on hardware).
REQ-003 Parameter CLOCKS_PER_BIT, default CLOCK_RATE / BAUD_RATE, clock cycles per serial bit; values below 4 are unsupported.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 rx_data  output  8  last correctly framed received byte.
REQ-008 rx_valid  output  1  one-cycle pulse when rx_data is updated.
REQ-009 frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 detected  output  1  one-cycle pulse when the sequence "Hello" completes.
REQ-011 match_count  output  8  number of detections, saturating.
REQ-012 receiving  output  1  high while the matcher is partway through the sequence (index != 0).

Function
REQ-013 rx SHALL pass through a two-flop synchronizer before any use.
REQ-014 The receiver FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-015 IDLE -> START on a synchronized falling edge (previous sample 1, current sample 0); the bit counter clears.
REQ-016 START: at count CLOCKS_PER_BIT/2 - 1 (integer division), sample low -> DATA; sample high -> IDLE (glitch rejected, no output).
REQ-017 DATA: every CLOCKS_PER_BIT cycles, sample one bit and shift it in LSB first; after the 8th bit -> STOP.
REQ-018 STOP: after CLOCKS_PER_BIT cycles, sample the line.
REQ-019 STOP sample high -> load rx_data, pulse rx_valid, go to IDLE.
REQ-020 STOP sample low -> pulse frame_error, leave rx_data unchanged, go to WAIT_IDLE.
REQ-021 WAIT_IDLE -> IDLE only once the synchronized line is high; a held-low break SHALL produce exactly one frame_error.
REQ-022 rx_valid SHALL assert at rising edge T0 + 2 + CLOCKS_PER_BIT/2 + 9*CLOCKS_PER_BIT, where T0 is the first edge at which rx is low.
REQ-023 The matcher SHALL hold a 3-bit index (0..4) into the constant string "Hello"; it acts only in cycles where rx_valid is high.
REQ-024 Byte equals message[index] and index < 4 -> index + 1.
REQ-025 Byte equals message[4] and index == 4 -> index 0; detected pulses the following cycle.
REQ-026 Mismatch and byte == "H" -> index 1; any other mismatch -> index 0.
REQ-027 A frame_error SHALL force index to 0.
REQ-028 match_count SHALL increment in the same cycle detected asserts and saturate at 255 with no wrap.
REQ-029 Back-to-back frames (the next start bit immediately after the stop bit) SHALL be received without loss.

Reset
REQ-030 In any cycle where rst is high, the next state SHALL be: FSM in IDLE, synchronizer at 1, and all of rx_data, rx_valid, frame_error, detected, match_count, receiving and index at 0.
REQ-031 rst asserted mid-frame SHALL abort the frame with no pulse; the next falling edge after release starts a fresh frame.
REQ-032 rst SHALL take priority over every other event in the same cycle.

Structure
REQ-033 A shared package, serial_pkg, SHALL hold the receiver state enum, the 8-bit byte type and the message constant "Hello" (length 5).
REQ-034 The receiver (REQ-013..REQ-022) SHALL be a sub-module named uart_rx with ports clk, rst, rx, data, valid and frame_error, and parameter CLOCKS_PER_BIT.
REQ-035 hello_detect SHALL contain the matcher, the counter and one uart_rx instance only.

Verification (CLOCKS_PER_BIT=5)
REQ-036 Frame 0x48 with a 1-cycle low glitch on rx before it -> no output for the glitch; exactly one rx_valid, rx_data=0x48, at the REQ-022 cycle.
REQ-037 "Hello" sent back-to-back -> five rx_valid pulses, detected once (cycle after the 'o' rx_valid), match_count=1, receiving low afterwards.
REQ-038 "HHello" and "HelHello" -> one detected each; "Helo" -> none, receiving 0 after the 'o'.
REQ-039 Frame 0x6C with stop bit low, then rx held low for 30 cycles -> one frame_error, rx_data unchanged, index 0; next "Hello" -> detected.
REQ-040 rst pulsed during data bit 4 of 'l' within "Hello" -> no rx_valid, match_count=0; subsequent "Hello" -> detected, match_count=1.
REQ-041 "Hello" repeated 260 times -> match_count stops at 255; detected continues to pulse.
